// File: rtl/mem_arb_pkg.sv
// Shared types and default limits for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int MAX_DSTREAK_DEF = 4;

    // Bits needed to hold values 0..maxVal inclusive.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory port,
// with a data-streak starvation guard and an access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);

    localparam int TW = cntWidth(TIMEOUT_CYC);
    localparam int SW = cntWidth(MAX_DSTREAK);

    arbState_t       state;
    arbState_t       stateNext;
    owner_t          owner;
    logic            weReg;
    logic            errPend;
    logic [TW-1:0]   timeCnt;
    logic [SW-1:0]   streakCnt;

    logic            streakFull;
    logic            grantFetch;
    logic            grantData;
    logic            timeoutHit;

    assign streakFull = (streakCnt == SW'(MAX_DSTREAK));
    // Data normally wins; a waiting fetch overrides once the streak limit is reached.
    assign grantFetch = if_req && (!d_req || streakFull);
    assign grantData  = d_req && !grantFetch;
    assign timeoutHit = (timeCnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready || timeoutHit) begin
                    stateNext = RESP;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        mem_en = (state == ACCESS);
        mem_we = (state == ACCESS) && weReg;
        if_ack = (state == RESP) && (owner == OWN_IF);
        d_ack  = (state == RESP) && (owner == OWN_D);
        err    = (state == RESP) && errPend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_IF;
            weReg     <= 1'b0;
            errPend   <= 1'b0;
            timeCnt   <= '0;
            streakCnt <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeCnt <= '0;
                    errPend <= 1'b0;
                    if (grantFetch) begin
                        owner     <= OWN_IF;
                        weReg     <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end else if (grantData) begin
                        owner     <= OWN_D;
                        weReg     <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                    // The streak only measures how long a fetch has been kept waiting.
                    if (!if_req || grantFetch) begin
                        streakCnt <= '0;
                    end else if (grantData && !streakFull) begin
                        streakCnt <= streakCnt + SW'(1);
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                        end else if (!weReg) begin
                            d_rdata <= mem_rdata;
                        end
                    end else if (timeoutHit) begin
                        errPend <= 1'b1;
                        if (owner == OWN_IF) begin
                            if_rdata <= '0;
                        end else begin
                            d_rdata <= '0;
                        end
                    end else begin
                        timeCnt <= timeCnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transactions are queued in grant order
// and retired by a negedge monitor that also models the memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYC(16), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    typedef struct {
        bit          isData;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        monE;
    int          total = 0;
    int          bad = 0;
    bit          memRespond = 1'b1;
    bit          useFixed = 1'b0;
    logic [31:0] fixedWord = '0;
    logic [31:0] shadowD = '0;

    function automatic logic [31:0] memModel(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic pushExp(input bit isData, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input bit e);
        exp_t x;
        x.isData = isData;
        x.we     = we;
        x.addr   = addr;
        x.wdata  = wdata;
        x.rdata  = rdata;
        x.err    = e;
        sbQ.push_back(x);
    endtask

    // Monitor + memory responder; memory answers in the first ACCESS cycle when enabled.
    always @(negedge clk) begin
        if (if_ack === 1'b1 && d_ack === 1'b1) begin
            total++; bad++;
            $display("FAIL ack_exclusive: if_ack=%b d_ack=%b required not both", if_ack, d_ack);
        end
        if (mem_en === 1'b1) begin
            total++;
            if (sbQ.size() == 0) begin
                bad++;
                $display("FAIL mem_en_unexpected: mem_en=1 addr=%h with nothing pending", mem_addr);
            end else if (mem_addr !== sbQ[0].addr || mem_we !== sbQ[0].we ||
                         (sbQ[0].we && mem_wdata !== sbQ[0].wdata)) begin
                bad++;
                $display("FAIL mem_bus: got addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                         mem_addr, mem_we, mem_wdata, sbQ[0].addr, sbQ[0].we, sbQ[0].wdata);
            end
        end
        if (if_ack === 1'b1 || d_ack === 1'b1) begin
            total++;
            if (sbQ.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected: if_ack=%b d_ack=%b err=%b", if_ack, d_ack, err);
            end else begin
                monE = sbQ.pop_front();
                if (d_ack !== monE.isData) begin
                    bad++;
                    $display("FAIL ack_owner: d_ack=%b required %b (addr %h)", d_ack, monE.isData, monE.addr);
                end else if (err !== monE.err) begin
                    bad++;
                    $display("FAIL ack_err: err=%b required %b", err, monE.err);
                end else if (monE.isData && d_rdata !== monE.rdata) begin
                    bad++;
                    $display("FAIL d_rdata: got %h required %h", d_rdata, monE.rdata);
                end else if (!monE.isData && if_rdata !== monE.rdata) begin
                    bad++;
                    $display("FAIL if_rdata: got %h required %h", if_rdata, monE.rdata);
                end
            end
        end
        mem_ready = memRespond && (mem_en === 1'b1);
        mem_rdata = mem_ready ? (useFixed ? fixedWord : memModel(mem_addr)) : 32'hDEAD_BEEF;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_en, mem_we, if_ack, d_ack, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: en/we/iack/dack/err=%b required 00000",
                     {mem_en, mem_we, if_ack, d_ack, err});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_membus: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
        end
        total++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h required 0", if_rdata, d_rdata);
        end
        rst = 1'b0;
        shadowD = '0;
        repeat (3) @(negedge clk);
        total++;
        if (mem_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: mem_en=%b required 0", mem_en);
        end
    endtask

    task automatic test_fetch_only();
        int cyc;
        bit seen;
        useFixed  = 1'b1;
        fixedWord = 32'h2008_0005;
        pushExp(1'b0, 1'b0, 32'h10, 32'h0, 32'h2008_0005, 1'b0);
        if_addr = 32'h10;
        if_req  = 1'b1;
        cyc  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (if_ack === 1'b1) seen = 1'b1;
        end
        if_req = 1'b0;
        total++;
        if (!seen || cyc != 3) begin
            bad++;
            $display("FAIL fetch_latency: ack seen=%0d at cycle %0d required cycle 3", seen, cyc);
        end
        total++;
        if (if_rdata !== 32'h2008_0005) begin
            bad++;
            $display("FAIL fetch_rdata: got %h required 20080005", if_rdata);
        end
        @(negedge clk);
        useFixed = 1'b0;
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("FAIL fetch_drain: %0d pending required 0", sbQ.size());
        end
    endtask

    task automatic test_starvation();
        int dCount;
        int fetchAt;
        logic [31:0] a;
        dCount  = 0;
        fetchAt = -1;
        for (int i = 0; i < 6; i++) begin
            a = 32'h100 + 32'(4 * i);
            if (i == 4) pushExp(1'b0, 1'b0, 32'h300, 32'h0, memModel(32'h300), 1'b0);
            pushExp(1'b1, 1'b0, a, 32'h0, memModel(a), 1'b0);
            shadowD = memModel(a);
        end
        d_we    = 1'b0;
        d_addr  = 32'h100;
        d_req   = 1'b1;
        if_addr = 32'h300;
        if_req  = 1'b1;
        for (int c = 0; c < 200 && (d_req || if_req); c++) begin
            @(negedge clk);
            if (d_ack === 1'b1) begin
                dCount++;
                if (dCount < 6) d_addr = 32'h100 + 32'(4 * dCount);
                else d_req = 1'b0;
            end
            if (if_ack === 1'b1) begin
                fetchAt = dCount;
                if_req  = 1'b0;
            end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        total++;
        if (fetchAt != 4) begin
            bad++;
            $display("FAIL starve_guard: fetch after %0d data grants required 4", fetchAt);
        end
        total++;
        if (dCount != 6) begin
            bad++;
            $display("FAIL starve_loads: %0d data acks required 6", dCount);
        end
        @(negedge clk);
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("FAIL starve_drain: %0d pending required 0", sbQ.size());
        end
    endtask

    task automatic test_simultaneous();
        int cyc, dCyc, iCyc;
        logic [31:0] prevD;
        prevD = shadowD;
        pushExp(1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5, prevD, 1'b0);
        pushExp(1'b0, 1'b0, 32'h200, 32'h0, memModel(32'h200), 1'b0);
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hA5A5_A5A5;
        d_req   = 1'b1;
        if_addr = 32'h200;
        if_req  = 1'b1;
        cyc = 0; dCyc = -1; iCyc = -1;
        for (int c = 0; c < 40 && (d_req || if_req); c++) begin
            @(negedge clk);
            cyc++;
            if (d_ack === 1'b1) begin dCyc = cyc; d_req = 1'b0; end
            if (if_ack === 1'b1) begin iCyc = cyc; if_req = 1'b0; end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        d_we   = 1'b0;
        total++;
        if (dCyc < 0 || iCyc < 0 || dCyc >= iCyc) begin
            bad++;
            $display("FAIL simul_order: d_ack cycle %0d if_ack cycle %0d required d first", dCyc, iCyc);
        end
        total++;
        if (d_rdata !== prevD) begin
            bad++;
            $display("FAIL store_rdata: d_rdata=%h required unchanged %h", d_rdata, prevD);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int accessCnt;
        bit seen, errAtAck;
        logic [31:0] rdAtAck;
        memRespond = 1'b0;
        pushExp(1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
        shadowD = '0;
        d_we   = 1'b0;
        d_addr = 32'h80;
        d_req  = 1'b1;
        accessCnt = 0; seen = 1'b0; errAtAck = 1'b0; rdAtAck = 32'hFFFF_FFFF;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mem_en === 1'b1) accessCnt++;
            if (d_ack === 1'b1) begin
                seen     = 1'b1;
                errAtAck = err;
                rdAtAck  = d_rdata;
                d_req    = 1'b0;
            end
        end
        d_req = 1'b0;
        memRespond = 1'b1;
        total++;
        if (!seen || accessCnt != 16) begin
            bad++;
            $display("FAIL timeout_len: seen=%0d access cycles %0d required 16", seen, accessCnt);
        end
        total++;
        if (errAtAck !== 1'b1 || rdAtAck !== 32'h0) begin
            bad++;
            $display("FAIL timeout_resp: err=%b d_rdata=%h required err=1 d_rdata=0", errAtAck, rdAtAck);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0 || d_ack !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: err=%b d_ack=%b required 0 after one cycle", err, d_ack);
        end
    endtask

    task automatic test_reset_mid();
        int accessCnt;
        memRespond = 1'b0;
        pushExp(1'b1, 1'b0, 32'h90, 32'h0, memModel(32'h90), 1'b0);
        d_we   = 1'b0;
        d_addr = 32'h90;
        d_req  = 1'b1;
        accessCnt = 0;
        for (int c = 0; c < 10 && accessCnt < 2; c++) begin
            @(negedge clk);
            if (mem_en === 1'b1) accessCnt++;
        end
        total++;
        if (accessCnt != 2) begin
            bad++;
            $display("FAIL rstmid_setup: access cycles %0d required 2", accessCnt);
        end
        #1;
        rst   = 1'b1;
        d_req = 1'b0;
        sbQ.delete();
        shadowD = '0;
        @(negedge clk);
        total++;
        if ({mem_en, mem_we, if_ack, d_ack, err} !== 5'b0) begin
            bad++;
            $display("FAIL rstmid_ctrl: en/we/iack/dack/err=%b required 00000",
                     {mem_en, mem_we, if_ack, d_ack, err});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h required 0",
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        rst = 1'b0;
        memRespond = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (if_ack !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0 || mem_en !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_quiet: iack=%b dack=%b err=%b en=%b required 0",
                         if_ack, d_ack, err, mem_en);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_fetch_only();
        test_starvation();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
